// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared encodings, state type and width constants for the mul/div unit
package mul_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        FINISH
    } state_t;

endpackage

// File: rtl/mul_div_seq_if.sv
// rtl/mul_div_seq_if.sv - start/busy/done handshake and operand/result bus of the mul/div unit
interface mul_div_seq_if
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    // control FSM side
    modport master (
        output start, op, a_in, b_in,
        input  hi_out, lo_out, busy, done, div_zero
    );

    // arithmetic unit side
    modport slave (
        input  start, op, a_in, b_in,
        output hi_out, lo_out, busy, done, div_zero
    );

endinterface

// File: rtl/div_restoring_core.sv
// rtl/div_restoring_core.sv - restoring divider on operand magnitudes with sign fixup
module div_restoring_core
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Magnitudes fit unsigned WIDTH bits, including the most negative value.
    // The partial remainder stays below |divisor| <= 2^(WIDTH-1), so the shifted
    // value fits WIDTH bits and bit WIDTH of the difference is a true sign bit.
    always_comb begin
        mag_a   = dividend[WIDTH-1] ? -dividend : dividend;
        mag_b   = divisor[WIDTH-1]  ? -divisor  : divisor;
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
    end

    // Load magnitudes and signs at accept, then one quotient bit per step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dvs    <= '0;
            quo    <= '0;
            rem    <= '0;
        end else if (load) begin
            sign_a <= dividend[WIDTH-1];
            sign_b <= divisor[WIDTH-1];
            dvs    <= mag_b;
            quo    <= mag_a;
            rem    <= '0;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend sign
    always_comb begin
        quotient  = (sign_a ^ sign_b) ? -quo : quo;
        remainder = sign_a ? -rem : rem;
    end

endmodule

// File: rtl/mul_div_seq.sv
// rtl/mul_div_seq.sv - sequential signed Booth multiplier / restoring divider feeding HI/LO
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_seq_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic                    op_r;
    logic signed [WIDTH:0]   acc;
    logic signed [WIDTH:0]   mcand;
    logic signed [WIDTH:0]   acc_sum;
    logic [WIDTH-1:0]        mplr;
    logic                    q_1;
    logic [WIDTH-1:0]        hi_r;
    logic [WIDTH-1:0]        lo_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    div_zero_r;
    logic                    div_load;
    logic [WIDTH-1:0]        div_quo;
    logic [WIDTH-1:0]        div_rem;

    // The accumulator carries one guard bit so subtracting the most negative
    // multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        acc_sum = acc;
        case ({mplr[0], q_1})
            2'b01:   acc_sum = acc + mcand;
            2'b10:   acc_sum = acc - mcand;
            default: acc_sum = acc;
        endcase
    end

    assign div_load = (state == IDLE) && bus.start && (bus.op == OP_DIV) && (bus.b_in != '0);

    div_restoring_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (state == DIV),
        .dividend  (bus.a_in),
        .divisor   (bus.b_in),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Control FSM with Booth iteration; results only move at the FINISH edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            op_r       <= OP_MULT;
            acc        <= '0;
            mcand      <= '0;
            mplr       <= '0;
            q_1        <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count      <= '0;
                        op_r       <= bus.op;
                        busy_r     <= 1'b1;
                        div_zero_r <= 1'b0;
                        if (bus.op == OP_MULT) begin
                            acc   <= '0;
                            mcand <= {bus.a_in[WIDTH-1], bus.a_in};
                            mplr  <= bus.b_in;
                            q_1   <= 1'b0;
                            state <= MULT;
                        end else if (bus.b_in == '0) begin
                            div_zero_r <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                MULT: begin
                    {acc, mplr, q_1} <= {acc_sum[WIDTH], acc_sum, mplr};
                    count            <= count + CNT_W'(1);
                    if (count == LAST_STEP) begin
                        state <= FINISH;
                    end
                end
                DIV: begin
                    count <= count + CNT_W'(1);
                    if (count == LAST_STEP) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (!div_zero_r) begin
                        if (op_r == OP_DIV) begin
                            hi_r <= div_rem;
                            lo_r <= div_quo;
                        end else begin
                            hi_r <= acc[WIDTH-1:0];
                            lo_r <= mplr;
                        end
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi_out   = hi_r;
    assign bus.lo_out   = lo_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_mul_div_seq.sv
// tb/tb_mul_div_seq.sv - scoreboard bench for the sequential mul/div unit
module tb_mul_div_seq;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   t0_cyc;
    int   n_checks;
    int   n_fail;
    exp_t scb[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    mul_div_seq_if #(.WIDTH(32)) bus ();

    mul_div_seq #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) check_eq("busy_done_excl", {63'd0, bus.busy & bus.done}, 64'd0);
    end

    function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            p    = 64'(sa * sb);
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            e.lat = 33;
        end else if (b == 32'd0) begin
            e.hi = last_hi;
            e.lo = last_lo;
            e.dz = 1'b1;
            e.lat = 1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.dz = 1'b0;
            e.lat = 33;
        end
        return e;
    endfunction

    // Drive one start pulse from IDLE; returns #1 after the accepting edge T0
    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, a, b);
        last_hi = e.hi;
        last_lo = e.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        t0_cyc = cyc;
        bus.start = 1'b0;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
        scb.push_back(e);
        check_eq("busy_after_t0", {63'd0, bus.busy}, 64'd1);
    endtask

    // Wait (bounded) for done, then compare against the scoreboard head
    task automatic collect(input string tag);
        exp_t e;
        for (int k = 0; k < 100; k++) begin
            if (bus.done) break;
            @(posedge clk);
            #1;
        end
        e = scb.pop_front();
        check_eq({tag, "_done"}, {63'd0, bus.done}, 64'd1);
        check_eq({tag, "_lat"}, 64'(cyc - t0_cyc), 64'(e.lat));
        check_eq({tag, "_hi"}, {32'd0, bus.hi_out}, {32'd0, e.hi});
        check_eq({tag, "_lo"}, {32'd0, bus.lo_out}, {32'd0, e.lo});
        check_eq({tag, "_dz"}, {63'd0, bus.div_zero}, {63'd0, e.dz});
        check_eq({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        last_hi   = '0;
        last_lo   = '0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        #12;
        check_eq("rst_hi", {32'd0, bus.hi_out}, 64'd0);
        check_eq("rst_lo", {32'd0, bus.lo_out}, 64'd0);
        check_eq("rst_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch(1'b0, 32'd7, -32'sd3);                collect("mult_7x-3");
        launch(1'b0, 32'h8000_0000, 32'h8000_0000);  collect("mult_min_sq");
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  collect("mult_m1_sq");
        launch(1'b1, -32'sd7, 32'd2);                collect("div_-7_2");
        launch(1'b1, 32'd7, -32'sd2);                collect("div_7_-2");
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  collect("div_min_m1");
        launch(1'b1, 32'h0000_BBAA, 32'h0000_0100);  collect("div_aa_bb");

        launch(1'b1, 32'd5, 32'd0);                  collect("div_zero");
        repeat (3) @(posedge clk);
        #1;
        check_eq("dz_sticky", {63'd0, bus.div_zero}, 64'd1);
        check_eq("dz_keep_hi", {32'd0, bus.hi_out}, 64'h0000_00AA);
        launch(1'b0, 32'd9, 32'd11);
        check_eq("dz_cleared", {63'd0, bus.div_zero}, 64'd0);
        collect("mult_after_dz");

        launch(1'b0, 32'd1234, -32'sd5678);
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 32'd100;
        bus.b_in  = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        collect("mult_ignore_start");

        launch(1'b1, 32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_hi", {32'd0, bus.hi_out}, 64'd0);
        check_eq("abort_lo", {32'd0, bus.lo_out}, 64'd0);
        check_eq("abort_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        void'(scb.pop_front());
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(1'b0, 32'd3, 32'd4);                  collect("mult_3x4");

        for (int k = 0; k < 6; k++) begin
            logic        rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (k == 3) ? 32'd0 : $urandom;
            launch(rop, ra, rb);
            collect("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
